// File: rtl/int_ctrl.sv
// Interrupt controller feeding the T-state sequencer: NMI/IRQ/RES pins in, brkNow/rstReq/vector out.
// Optional NMI_HIJACK_EN lets a late NMI redirect an IRQ sequence that has not yet fetched its vector.
module int_ctrl #(
    parameter logic [15:0] VEC_NMI     = 16'hFFFA,
    parameter logic [15:0] VEC_RST     = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ     = 16'hFFFE,
    parameter int          RST_STRETCH = 2
) (
    input  logic        phi1,
    input  logic        rst,
    input  logic        haltAll,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        res_n,
    input  logic        iFlag,
    input  logic        fetchSlot,
    input  logic        intHandled,
    input  logic        vecFetch,
    output logic        brkNow,
    output logic        rstReq,
    output logic [15:0] vecAddr,
    output logic [1:0]  intSrc,
    output logic        nmiPend
);

    localparam int CW = (RST_STRETCH < 2) ? 1 : $clog2(RST_STRETCH + 1);
    localparam logic [CW-1:0] STRETCH_LOAD = CW'(RST_STRETCH);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_IRQ  = 2'b01,
        SRC_NMI  = 2'b10,
        SRC_RST  = 2'b11
    } src_t;

    logic          nmi_prev_reg,   nmi_prev_next;
    logic          nmi_pend_reg,   nmi_pend_next;
    logic          brk_reg,        brk_next;
    logic          in_seq_reg,     in_seq_next;
    logic          vec_locked_reg, vec_locked_next;
    logic          rst_req_reg,    rst_req_next;
    logic [CW-1:0] cnt_reg,        cnt_next;
    src_t          src_reg,        src_next;
    logic [15:0]   vec_reg,        vec_next;

    logic nmi_edge;
    logic irq_req;
    logic retire;

    assign nmi_edge = nmi_prev_reg & ~nmi_n;
    assign irq_req  = ~irq_n & ~iFlag;
    assign retire   = in_seq_reg & intHandled;

    always_comb begin
        nmi_prev_next   = nmi_n;
        nmi_pend_next   = nmi_pend_reg;
        brk_next        = brk_reg;
        in_seq_next     = in_seq_reg;
        vec_locked_next = vec_locked_reg;
        rst_req_next    = rst_req_reg;
        cnt_next        = cnt_reg;
        src_next        = src_reg;
        vec_next        = vec_reg;

        // A new edge beats the clear from retiring an NMI sequence.
        if (nmi_edge) begin
            nmi_pend_next = 1'b1;
        end else if (retire && src_reg == SRC_NMI) begin
            nmi_pend_next = 1'b0;
        end

        if (!res_n) begin
            rst_req_next = 1'b1;
            cnt_next     = STRETCH_LOAD;
        end else if (rst_req_reg) begin
            if (cnt_reg <= CNT_ONE) begin
                cnt_next     = '0;
                rst_req_next = 1'b0;
            end else begin
                cnt_next = cnt_reg - CNT_ONE;
            end
        end

        if (!res_n || rst_req_reg) begin
            // The reset sequence itself becomes the pending sequence once the request drops.
            nmi_pend_next   = 1'b0;
            brk_next        = 1'b0;
            in_seq_next     = ~rst_req_next;
            vec_locked_next = 1'b0;
            src_next        = SRC_RST;
            vec_next        = VEC_RST;
        end else if (in_seq_reg) begin
            brk_next = 1'b0;
            if (intHandled) begin
                in_seq_next     = 1'b0;
                vec_locked_next = 1'b0;
                src_next        = SRC_NONE;
                vec_next        = VEC_IRQ;
            end else begin
                if (vecFetch) begin
                    vec_locked_next = 1'b1;
                end
`ifdef NMI_HIJACK_EN
                if (src_reg == SRC_IRQ && !vec_locked_reg && (nmi_edge || nmi_pend_reg)) begin
                    src_next = SRC_NMI;
                    vec_next = VEC_NMI;
                end
`endif
            end
        end else if (brk_reg && fetchSlot) begin
            in_seq_next = 1'b1;
            brk_next    = 1'b0;
        end else begin
            brk_next = nmi_pend_reg | irq_req;
            if (nmi_pend_reg) begin
                src_next = SRC_NMI;
                vec_next = VEC_NMI;
            end else if (irq_req) begin
                src_next = SRC_IRQ;
                vec_next = VEC_IRQ;
            end else begin
                src_next = SRC_NONE;
                vec_next = VEC_IRQ;
            end
        end
    end

    always_ff @(posedge phi1) begin
        if (!rst) begin
            nmi_prev_reg   <= 1'b1;
            nmi_pend_reg   <= 1'b0;
            brk_reg        <= 1'b0;
            in_seq_reg     <= 1'b0;
            vec_locked_reg <= 1'b0;
            rst_req_reg    <= 1'b1;
            cnt_reg        <= STRETCH_LOAD;
            src_reg        <= SRC_RST;
            vec_reg        <= VEC_RST;
        end else if (!haltAll) begin
            nmi_prev_reg   <= nmi_prev_next;
            nmi_pend_reg   <= nmi_pend_next;
            brk_reg        <= brk_next;
            in_seq_reg     <= in_seq_next;
            vec_locked_reg <= vec_locked_next;
            rst_req_reg    <= rst_req_next;
            cnt_reg        <= cnt_next;
            src_reg        <= src_next;
            vec_reg        <= vec_next;
        end
    end

    assign brkNow  = brk_reg;
    assign rstReq  = rst_req_reg;
    assign vecAddr = vec_reg;
    assign intSrc  = src_reg;
    assign nmiPend = nmi_pend_reg;

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: each cycle's expected output snapshot is queued with its stimulus
// and compared against the captured DUT snapshot at the end of each scenario.
module tb_int_ctrl;

    logic        phi1 = 1'b0;
    logic        rst, haltAll, nmi_n, irq_n, res_n, iFlag, fetchSlot, intHandled, vecFetch;
    logic        brkNow, rstReq, nmiPend;
    logic [15:0] vecAddr;
    logic [1:0]  intSrc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [20:0] val;
    } ent_t;

    ent_t        exp_q[$];
    logic [20:0] obs_q[$];
    ent_t        e;
    logic [20:0] o;

    int_ctrl dut (
        .phi1(phi1), .rst(rst), .haltAll(haltAll), .nmi_n(nmi_n), .irq_n(irq_n),
        .res_n(res_n), .iFlag(iFlag), .fetchSlot(fetchSlot), .intHandled(intHandled),
        .vecFetch(vecFetch), .brkNow(brkNow), .rstReq(rstReq), .vecAddr(vecAddr),
        .intSrc(intSrc), .nmiPend(nmiPend)
    );

    always #5 phi1 = ~phi1;

    function automatic logic [20:0] mk(input logic b, input logic r, input logic [1:0] s,
                                       input logic p, input logic [15:0] v);
        return {b, r, s, p, v};
    endfunction

    // Advance one clock, queue the expectation and capture the DUT snapshot 1ns after the edge.
    task automatic cyc(input string tag, input logic [20:0] expv);
        ent_t x;
        @(posedge phi1);
        #1;
        x.tag = tag;
        x.val = expv;
        exp_q.push_back(x);
        obs_q.push_back({brkNow, rstReq, intSrc, nmiPend, vecAddr});
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc("rst_active",   mk(0, 1, 2'b11, 0, 16'hFFFC));
        rst = 1'b1;
        cyc("stretch_1",    mk(0, 1, 2'b11, 0, 16'hFFFC));
        cyc("stretch_end",  mk(0, 0, 2'b11, 0, 16'hFFFC));
        cyc("rst_seq_hold", mk(0, 0, 2'b11, 0, 16'hFFFC));
        intHandled = 1'b1;
        cyc("rst_retire",   mk(0, 0, 2'b00, 0, 16'hFFFE));
        intHandled = 1'b0;
        cyc("idle_after",   mk(0, 0, 2'b00, 0, 16'hFFFE));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: got brk=%b rreq=%b src=%b pend=%b vec=%h, expected brk=%b rreq=%b src=%b pend=%b vec=%h",
                         e.tag, o[20], o[19], o[18:17], o[16], o[15:0],
                         e.val[20], e.val[19], e.val[18:17], e.val[16], e.val[15:0]);
            end
        end
    endtask

    task automatic test_irq();
        irq_n = 1'b0;
        cyc("irq_arm",      mk(1, 0, 2'b01, 0, 16'hFFFE));
        fetchSlot = 1'b1;
        cyc("irq_take",     mk(0, 0, 2'b01, 0, 16'hFFFE));
        fetchSlot = 1'b0;
        cyc("irq_inseq_a",  mk(0, 0, 2'b01, 0, 16'hFFFE));
        cyc("irq_inseq_b",  mk(0, 0, 2'b01, 0, 16'hFFFE));
        intHandled = 1'b1;
        cyc("irq_retire",   mk(0, 0, 2'b00, 0, 16'hFFFE));
        intHandled = 1'b0;
        cyc("irq_rearm",    mk(1, 0, 2'b01, 0, 16'hFFFE));
        iFlag = 1'b1;
        cyc("irq_masked_a", mk(0, 0, 2'b00, 0, 16'hFFFE));
        cyc("irq_masked_b", mk(0, 0, 2'b00, 0, 16'hFFFE));
        irq_n = 1'b1;
        iFlag = 1'b0;
        cyc("irq_idle",     mk(0, 0, 2'b00, 0, 16'hFFFE));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: got brk=%b rreq=%b src=%b pend=%b vec=%h, expected brk=%b rreq=%b src=%b pend=%b vec=%h",
                         e.tag, o[20], o[19], o[18:17], o[16], o[15:0],
                         e.val[20], e.val[19], e.val[18:17], e.val[16], e.val[15:0]);
            end
        end
    endtask

    task automatic test_nmi_priority();
        nmi_n = 1'b0;
        irq_n = 1'b0;
        cyc("pri_c1_irq",   mk(1, 0, 2'b01, 1, 16'hFFFE));
        cyc("pri_c2_nmi",   mk(1, 0, 2'b10, 1, 16'hFFFA));
        fetchSlot = 1'b1;
        cyc("pri_take",     mk(0, 0, 2'b10, 1, 16'hFFFA));
        fetchSlot = 1'b0;
        vecFetch = 1'b1;
        cyc("pri_vecfetch", mk(0, 0, 2'b10, 1, 16'hFFFA));
        vecFetch = 1'b0;
        intHandled = 1'b1;
        cyc("pri_retire",   mk(0, 0, 2'b00, 0, 16'hFFFE));
        intHandled = 1'b0;
        cyc("pri_irq_next", mk(1, 0, 2'b01, 0, 16'hFFFE));
        fetchSlot = 1'b1;
        cyc("pri_irq_take", mk(0, 0, 2'b01, 0, 16'hFFFE));
        fetchSlot = 1'b0;
        irq_n = 1'b1;
        nmi_n = 1'b1;
        intHandled = 1'b1;
        cyc("pri_irq_ret",  mk(0, 0, 2'b00, 0, 16'hFFFE));
        intHandled = 1'b0;
        cyc("pri_idle",     mk(0, 0, 2'b00, 0, 16'hFFFE));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: got brk=%b rreq=%b src=%b pend=%b vec=%h, expected brk=%b rreq=%b src=%b pend=%b vec=%h",
                         e.tag, o[20], o[19], o[18:17], o[16], o[15:0],
                         e.val[20], e.val[19], e.val[18:17], e.val[16], e.val[15:0]);
            end
        end
    endtask

    task automatic test_halt_nmi();
        haltAll = 1'b1;
        nmi_n = 1'b0;
        cyc("halt_a",        mk(0, 0, 2'b00, 0, 16'hFFFE));
        cyc("halt_b",        mk(0, 0, 2'b00, 0, 16'hFFFE));
        haltAll = 1'b0;
        cyc("unhalt_pend",   mk(0, 0, 2'b00, 1, 16'hFFFE));
        cyc("unhalt_arm",    mk(1, 0, 2'b10, 1, 16'hFFFA));
        fetchSlot = 1'b1;
        cyc("halt_take",     mk(0, 0, 2'b10, 1, 16'hFFFA));
        fetchSlot = 1'b0;
        nmi_n = 1'b1;
        cyc("nmi_high",      mk(0, 0, 2'b10, 1, 16'hFFFA));
        nmi_n = 1'b0;
        intHandled = 1'b1;
        cyc("edge_on_clear", mk(0, 0, 2'b00, 1, 16'hFFFE));
        intHandled = 1'b0;
        cyc("nmi2_arm",      mk(1, 0, 2'b10, 1, 16'hFFFA));
        fetchSlot = 1'b1;
        cyc("nmi2_take",     mk(0, 0, 2'b10, 1, 16'hFFFA));
        fetchSlot = 1'b0;
        intHandled = 1'b1;
        cyc("nmi2_retire",   mk(0, 0, 2'b00, 0, 16'hFFFE));
        intHandled = 1'b0;
        nmi_n = 1'b1;
        cyc("halt_idle",     mk(0, 0, 2'b00, 0, 16'hFFFE));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: got brk=%b rreq=%b src=%b pend=%b vec=%h, expected brk=%b rreq=%b src=%b pend=%b vec=%h",
                         e.tag, o[20], o[19], o[18:17], o[16], o[15:0],
                         e.val[20], e.val[19], e.val[18:17], e.val[16], e.val[15:0]);
            end
        end
    endtask

    task automatic test_res_mid_seq();
        irq_n = 1'b0;
        cyc("res_irq_arm",  mk(1, 0, 2'b01, 0, 16'hFFFE));
        fetchSlot = 1'b1;
        cyc("res_irq_take", mk(0, 0, 2'b01, 0, 16'hFFFE));
        fetchSlot = 1'b0;
        vecFetch = 1'b1;
        cyc("res_vecfetch", mk(0, 0, 2'b01, 0, 16'hFFFE));
        vecFetch = 1'b0;
        nmi_n = 1'b0;
        cyc("res_nmi_pend", mk(0, 0, 2'b01, 1, 16'hFFFE));
        res_n = 1'b0;
        cyc("res_low_a",    mk(0, 1, 2'b11, 0, 16'hFFFC));
        cyc("res_low_b",    mk(0, 1, 2'b11, 0, 16'hFFFC));
        res_n = 1'b1;
        cyc("res_stretch",  mk(0, 1, 2'b11, 0, 16'hFFFC));
        cyc("res_fall",     mk(0, 0, 2'b11, 0, 16'hFFFC));
        irq_n = 1'b1;
        nmi_n = 1'b1;
        intHandled = 1'b1;
        cyc("res_retire",   mk(0, 0, 2'b00, 0, 16'hFFFE));
        intHandled = 1'b0;
        cyc("res_idle",     mk(0, 0, 2'b00, 0, 16'hFFFE));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: got brk=%b rreq=%b src=%b pend=%b vec=%h, expected brk=%b rreq=%b src=%b pend=%b vec=%h",
                         e.tag, o[20], o[19], o[18:17], o[16], o[15:0],
                         e.val[20], e.val[19], e.val[18:17], e.val[16], e.val[15:0]);
            end
        end
    endtask

    task automatic test_hijack();
        irq_n = 1'b0;
        cyc("hj_irq_arm",   mk(1, 0, 2'b01, 0, 16'hFFFE));
        fetchSlot = 1'b1;
        cyc("hj_irq_take",  mk(0, 0, 2'b01, 0, 16'hFFFE));
        fetchSlot = 1'b0;
        nmi_n = 1'b0;
`ifdef NMI_HIJACK_EN
        cyc("hj_switch",    mk(0, 0, 2'b10, 1, 16'hFFFA));
        vecFetch = 1'b1;
        cyc("hj_vecfetch",  mk(0, 0, 2'b10, 1, 16'hFFFA));
        vecFetch = 1'b0;
        irq_n = 1'b1;
        intHandled = 1'b1;
        cyc("hj_retire",    mk(0, 0, 2'b00, 0, 16'hFFFE));
        intHandled = 1'b0;
        cyc("hj_idle",      mk(0, 0, 2'b00, 0, 16'hFFFE));
`else
        cyc("hj_frozen",    mk(0, 0, 2'b01, 1, 16'hFFFE));
        vecFetch = 1'b1;
        cyc("hj_vecfetch",  mk(0, 0, 2'b01, 1, 16'hFFFE));
        vecFetch = 1'b0;
        irq_n = 1'b1;
        intHandled = 1'b1;
        cyc("hj_retire",    mk(0, 0, 2'b00, 1, 16'hFFFE));
        intHandled = 1'b0;
        cyc("hj_nmi_arm",   mk(1, 0, 2'b10, 1, 16'hFFFA));
        fetchSlot = 1'b1;
        cyc("hj_nmi_take",  mk(0, 0, 2'b10, 1, 16'hFFFA));
        fetchSlot = 1'b0;
        intHandled = 1'b1;
        cyc("hj_nmi_ret",   mk(0, 0, 2'b00, 0, 16'hFFFE));
        intHandled = 1'b0;
`endif
        nmi_n = 1'b1;
        cyc("hj_end",       mk(0, 0, 2'b00, 0, 16'hFFFE));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL %s: got brk=%b rreq=%b src=%b pend=%b vec=%h, expected brk=%b rreq=%b src=%b pend=%b vec=%h",
                         e.tag, o[20], o[19], o[18:17], o[16], o[15:0],
                         e.val[20], e.val[19], e.val[18:17], e.val[16], e.val[15:0]);
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        haltAll    = 1'b0;
        nmi_n      = 1'b1;
        irq_n      = 1'b1;
        res_n      = 1'b1;
        iFlag      = 1'b0;
        fetchSlot  = 1'b0;
        intHandled = 1'b0;
        vecFetch   = 1'b0;
        test_reset();
        test_irq();
        test_nmi_priority();
        test_halt_nmi();
        test_res_mid_seq();
        test_hijack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
